// File: rtl/potato1_host_sequencer.sv
// Host-side sequencer for one Potato-1 core: owns program memory, PC, tape pointer and tape RAM,
// clocks the core through SETUP/RISE/FALL/EXEC and bridges PUT/GET to valid/ready byte streams.
module potato1_host_sequencer #(
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [7:0]            core_in_o,
  input  logic [7:0]            core_out_i,
  input  logic                  prog_we_i,
  input  logic [PC_WIDTH-1:0]   prog_addr_i,
  input  logic [3:0]            prog_data_i,
  input  logic                  run_i,
  output logic                  out_valid_o,
  output logic [7:0]            out_data_o,
  input  logic                  out_ready_i,
  input  logic                  in_valid_i,
  input  logic [7:0]            in_data_i,
  output logic                  in_ready_o,
  output logic                  running_o,
  output logic                  halted_o,
  output logic                  fault_o
);

  localparam int unsigned PROG_DEPTH = 2 ** PC_WIDTH;
  localparam int unsigned TAPE_DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [3:0] {
    IDLE, CLEAR, SETUP, RISE, FALL, EXEC, PUT, GET, HALT, FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] x_q, x_d;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [7:0]            core_in_q, core_in_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_data_q, out_data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  running_q, running_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;

  logic [3:0]            prog_mem [PROG_DEPTH];
  logic [7:0]            tape_mem [TAPE_DEPTH];

  logic                  tape_we;
  logic [ADDR_WIDTH-1:0] tape_waddr;
  logic [7:0]            tape_wdata;
  logic [7:0]            tape_x_d;
  logic                  cmd_io;
  logic                  cmd_fault;

  assign cmd_io    = cmd_q[6] | cmd_q[7];
  assign cmd_fault = (cmd_q[1:0] == 2'b11) || (cmd_q[1] && (pc_q == '0)) ||
                     (cmd_io && (|cmd_q[5:2]));

  // Next-state, datapath updates and registered-output lookahead
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    x_d        = x_q;
    clr_d      = clr_q;
    cmd_d      = cmd_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    tape_we    = 1'b0;
    tape_waddr = x_q;
    tape_wdata = in_data_i;

    case (state_q)
      IDLE: begin
        if (run_i) begin
          state_d = CLEAR;
          pc_d    = '0;
          x_d     = '0;
          clr_d   = '0;
        end
      end
      CLEAR: begin
        tape_we    = 1'b1;
        tape_waddr = clr_q;
        tape_wdata = 8'h00;
        clr_d      = clr_q + ADDR_WIDTH'(1);
        if (clr_q == ADDR_WIDTH'(TAPE_DEPTH - 1)) state_d = SETUP;
      end
      SETUP: state_d = RISE;
      RISE:  state_d = FALL;
      FALL: begin
        cmd_d   = core_out_i;
        state_d = EXEC;
      end
      EXEC: begin
        if (cmd_fault) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else if (cmd_q[1:0] == 2'b00) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          pc_d       = pc_q + PC_WIDTH'(cmd_q[0]) - PC_WIDTH'(cmd_q[1]);
          x_d        = x_q + ADDR_WIDTH'(cmd_q[2]) - ADDR_WIDTH'(cmd_q[3]);
          tape_we    = cmd_q[4] | cmd_q[5];
          tape_wdata = tape_mem[x_q] + 8'(cmd_q[4]) - 8'(cmd_q[5]);
          if (cmd_q[6])      state_d = PUT;
          else if (cmd_q[7]) state_d = GET;
          else               state_d = SETUP;
        end
      end
      PUT: begin
        if (out_valid_q && out_ready_i) state_d = SETUP;
      end
      GET: begin
        if (in_valid_i && in_ready_q) begin
          tape_we = 1'b1;
          state_d = SETUP;
        end
      end
      HALT, FAULT: begin
        if (!run_i) begin
          state_d  = IDLE;
          halted_d = 1'b0;
          fault_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Zero flag must see this cycle's tape write and pointer move
    tape_x_d = (tape_we && (tape_waddr == x_d)) ? tape_wdata : tape_mem[x_d];

    core_in_d = core_in_q;
    case (state_d)
      IDLE, CLEAR: core_in_d[2:0] = 3'b000;
      SETUP:       core_in_d = {prog_mem[pc_d], (tape_x_d == 8'h00), 3'b010};
      RISE:        core_in_d[0] = 1'b1;
      FALL:        core_in_d[0] = 1'b0;
      default:     ;
    endcase

    out_valid_d = (state_d == PUT);
    out_data_d  = tape_x_d;
    in_ready_d  = (state_d == GET);
    running_d   = state_d inside {CLEAR, SETUP, RISE, FALL, EXEC, PUT, GET};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      x_q         <= '0;
      clr_q       <= '0;
      cmd_q       <= '0;
      core_in_q   <= 8'hF0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      x_q         <= x_d;
      clr_q       <= clr_d;
      cmd_q       <= cmd_d;
      core_in_q   <= core_in_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
    end
  end

  // Tape and program storage are not reset; reset suppresses any write in flight
  always_ff @(posedge clk_i) begin
    if (!rst_i && tape_we) tape_mem[tape_waddr] <= tape_wdata;
    if (!rst_i && prog_we_i && (state_q == IDLE)) prog_mem[prog_addr_i] <= prog_data_i;
  end

  assign core_in_o   = core_in_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign in_ready_o  = in_ready_q;
  assign running_o   = running_q;
  assign halted_o    = halted_q;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_potato1_host_sequencer.sv
// Bench for potato1_host_sequencer: behavioural Potato-1 core (brainfuck-style ISA) plus
// directed program vectors, a stubbed-core fault sweep and reset/program-protect sequences.
module tb_potato1_host_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, prog_we, out_ready, in_valid;
  logic [7:0] prog_addr, in_data;
  logic [3:0] prog_data;
  logic [7:0] core_in, core_out, out_data;
  logic       out_valid, in_ready, running, halted, fault;
  logic       use_stub;
  logic [7:0] stub_val;
  logic [7:0] core_model_out = 8'h00;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  potato1_host_sequencer #(.PC_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_in_o(core_in), .core_out_i(core_out),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
    .run_i(run),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .running_o(running), .halted_o(halted), .fault_o(fault)
  );

  assign core_out = use_stub ? stub_val : core_model_out;

  // Core model: 0 > 1 < 2 + 3 - 4 . 5 , 6 [ 7 ] F halt; loops resolved by scanning the PC.
  typedef struct packed {
    logic [1:0] mode;   // 0 normal, 1 scan forward, 2 scan back
    logic [7:0] depth;
    logic [7:0] cmd;
  } core_st_t;

  core_st_t cst = '0;

  function automatic core_st_t core_step(input core_st_t s, input logic [3:0] ins, input logic z);
    core_st_t n;
    n     = s;
    n.cmd = 8'h01;
    case (s.mode)
      2'd0: begin
        case (ins)
          4'h0: n.cmd = 8'h05;
          4'h1: n.cmd = 8'h09;
          4'h2: n.cmd = 8'h11;
          4'h3: n.cmd = 8'h21;
          4'h4: n.cmd = 8'h41;
          4'h5: n.cmd = 8'h81;
          4'h6: if (z) begin n.mode = 2'd1; n.depth = 8'd1; end
          4'h7: if (!z) begin n.mode = 2'd2; n.depth = 8'd1; n.cmd = 8'h02; end
          4'hF: n.cmd = 8'h00;
          default: ;
        endcase
      end
      2'd1: begin
        if (ins == 4'h6) n.depth = s.depth + 8'd1;
        else if (ins == 4'h7) begin
          n.depth = s.depth - 8'd1;
          if (s.depth == 8'd1) n.mode = 2'd0;
        end
      end
      default: begin
        if (ins == 4'h7) begin
          n.depth = s.depth + 8'd1;
          n.cmd   = 8'h02;
        end else if (ins == 4'h6 && s.depth == 8'd1) begin
          n.mode  = 2'd0;
          n.depth = 8'd0;
        end else begin
          if (ins == 4'h6) n.depth = s.depth - 8'd1;
          n.cmd = 8'h02;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge core_in[0] or negedge core_in[1]) begin
    if (!core_in[1]) cst <= '0;
    else             cst <= core_step(cst, core_in[7:4], core_in[3]);
  end

  always @(negedge core_in[0]) core_model_out <= cst.cmd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_prog(input logic [31:0] w, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 8'(i);
      prog_data = w[4*i +: 4];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Raise Run and serve the streams until HALT/FAULT (bounded)
  task automatic run_prog(input logic [7:0] in_byte, input int get_delay, input bit inject,
                          output int puts, output logic [7:0] last, output bit moved);
    int gw;
    bit done;
    gw    = 0;
    done  = 1'b0;
    puts  = 0;
    last  = 8'h00;
    moved = 1'b0;
    @(negedge clk);
    run = 1'b1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      prog_we   = inject && (cyc == 0);
      prog_addr = 8'd2;
      prog_data = 4'hF;
      if (out_valid && out_ready) begin
        puts++;
        last = out_data;
      end
      if (in_ready) begin
        if (gw < get_delay) begin
          gw++;
          in_valid = 1'b0;
          if (core_in[0]) moved = 1'b1;
        end else begin
          in_valid = 1'b1;
          in_data  = in_byte;
        end
      end else begin
        in_valid = 1'b0;
      end
      if (halted || fault) done = 1'b1;
    end
    prog_we  = 1'b0;
    in_valid = 1'b0;
    chk("run_terminated", 32'(done), 32'd1);
  endtask

  task automatic finish_run();
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_running", 32'(running), 32'd0);
    chk("idle_flags", {30'd0, halted, fault}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] prog;
    int          len;
    logic [7:0]  in_byte;
    int          get_delay;
    logic [7:0]  exp_out;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int         puts;
    logic [7:0] last;
    bit         moved;
    bit         got;
    logic [7:0] stub_vals[4];
    logic       stub_fault[4];

    rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    out_ready = 1'b1; in_valid = 1'b0; in_data = '0; use_stub = 1'b0; stub_val = '0;

    // word 0 in the low nibble
    vecs[0] = '{32'h0000_F422, 4, 8'h00, 0,  8'h02, 8'd3};  // ++ . halt
    vecs[1] = '{32'hF473_6222, 8, 8'h00, 0,  8'h00, 8'd7};  // +++ [-] . halt
    vecs[2] = '{32'h0000_0F45, 3, 8'hA5, 10, 8'hA5, 8'd2};  // , . halt with slow input
    vecs[3] = '{32'h0000_0F42, 3, 8'h00, 0,  8'h01, 8'd2};  // tape cleared after previous GET
    vecs[4] = '{32'h0000_F431, 4, 8'h00, 0,  8'hFF, 8'd3};  // < - . : X and cell wrap
    vecs[5] = '{32'h000F_4726, 5, 8'h00, 0,  8'h00, 8'd4};  // [ + ] . : forward skip

    repeat (3) @(negedge clk);
    chk("rst_core_in", 32'(core_in), 32'h0000_00F0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_flags", {30'd0, halted, fault}, 32'd0);
    chk("rst_pc", 32'(dut.pc_q), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      load_prog(vecs[v].prog, vecs[v].len);
      run_prog(vecs[v].in_byte, vecs[v].get_delay, 1'b0, puts, last, moved);
      chk($sformatf("v%0d_put_count", v), 32'(puts), 32'd1);
      chk($sformatf("v%0d_out_data", v), 32'(last), 32'(vecs[v].exp_out));
      chk($sformatf("v%0d_halted", v), 32'(halted), 32'd1);
      chk($sformatf("v%0d_fault", v), 32'(fault), 32'd0);
      chk($sformatf("v%0d_pc", v), 32'(dut.pc_q), 32'(vecs[v].exp_pc));
      if (vecs[v].get_delay > 0) chk($sformatf("v%0d_core_clk_frozen", v), 32'(moved), 32'd0);
      finish_run();
    end

    // Stubbed core: illegal PC commands and I/O mixed with X/A fault; 00 halts
    stub_vals  = '{8'h02, 8'h03, 8'h45, 8'h00};
    stub_fault = '{1'b1, 1'b1, 1'b1, 1'b0};
    use_stub   = 1'b1;
    for (int s = 0; s < 4; s++) begin
      stub_val = stub_vals[s];
      run_prog(8'h00, 0, 1'b0, puts, last, moved);
      chk($sformatf("stub%0d_fault", s), 32'(fault), 32'(stub_fault[s]));
      chk($sformatf("stub%0d_halted", s), 32'(halted), 32'(!stub_fault[s]));
      chk($sformatf("stub%0d_pc", s), 32'(dut.pc_q), 32'd0);
      chk($sformatf("stub%0d_no_put", s), 32'(puts), 32'd0);
      finish_run();
    end
    use_stub = 1'b0;

    // Reset in the middle of a stalled PUT
    load_prog(32'h0000_F422, 4);
    out_ready = 1'b0;
    @(negedge clk);
    run = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    chk("t6_put_reached", 32'(got), 32'd1);
    repeat (3) @(negedge clk);
    chk("t6_valid_held", 32'(out_valid), 32'd1);
    chk("t6_stall_data", 32'(out_data), 32'h02);
    chk("t6_core_clk_low", 32'(core_in[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_valid_after_rst", 32'(out_valid), 32'd0);
    chk("t6_core_in_after_rst", 32'(core_in), 32'h0000_00F0);
    chk("t6_running_after_rst", 32'(running), 32'd0);
    chk("t6_state_idle", 32'(dut.state_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // A program write issued while running must be dropped
    load_prog(32'h0000_F422, 4);
    run_prog(8'h00, 0, 1'b1, puts, last, moved);
    chk("t6_prog_protect_puts", 32'(puts), 32'd1);
    chk("t6_prog_protect_data", 32'(last), 32'h02);
    chk("t6_prog_protect_halt", 32'(halted), 32'd1);
    finish_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
